// File: rtl/param_bank_pkg.sv
// Shared definitions for the parameter-entry controller: FSM encoding,
// button bit positions and active-low 7-segment glyphs (bit 0 = segment a).
package param_bank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam int BTN_ABORT = 3;
  localparam int BTN_NEXT  = 2;
  localparam int BTN_SAVE  = 1;
  localparam int BTN_PREV  = 0;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_B    = 7'h03;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_F    = 7'h0E;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_P    = 7'h0C;
  localparam logic [6:0] SEG_I    = 7'h79;
  localparam logic [6:0] SEG_L    = 7'h47;

endpackage

// File: rtl/param_bank_if.sv
// Operator-panel and publish bus of param_bank: switches and buttons in,
// published fields, update pulse, LEDs and 7-segment digits out.
// Parameters must match those of the param_bank instance using it.
interface param_bank_if #(
  parameter int NUM_PARAMS = 12,
  parameter int BIT_WIDTH  = 10,
  parameter int SW_WIDTH   = 10
);
  logic [SW_WIDTH-1:0]             SW;
  logic [3:0]                      db_btn_n;
  logic [NUM_PARAMS*BIT_WIDTH-1:0] params;
  logic                            params_upd;
  logic [SW_WIDTH-1:0]             LEDR;
  logic [6:0]                      HEX3;
  logic [6:0]                      HEX2;
  logic [6:0]                      HEX1;
  logic [6:0]                      HEX0;

  modport master (
    output SW, db_btn_n,
    input  params, params_upd, LEDR, HEX3, HEX2, HEX1, HEX0
  );

  modport slave (
    input  SW, db_btn_n,
    output params, params_upd, LEDR, HEX3, HEX2, HEX1, HEX0
  );
endinterface

// File: rtl/param_bank_hex7seg.sv
// hex7seg: combinational 4-bit value to active-low 7-segment glyph.
// Zero latency; no state. Callers register the result.
module hex7seg
  import param_bank_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Glyph lookup for one hex digit
  always_comb begin
    seg = SEG_DASH;
    case (val)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/param_bank.sv
// param_bank: operator walks NUM_PARAMS fields in SW_WIDTH-bit pages with buttons,
// edits a working copy and publishes it atomically when the walk completes.
// Optional macro PARAM_BANK_PREV_EN enables the prev button (db_btn_n[0]).
module param_bank
  import param_bank_pkg::*;
#(
  parameter int NUM_PARAMS = 12,
  parameter int BIT_WIDTH  = 10,
  parameter int SW_WIDTH   = 10
) (
  input logic         clk,
  input logic         rst_n,
  param_bank_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PARAMS);
  localparam int PAGES = (BIT_WIDTH + SW_WIDTH - 1) / SW_WIDTH;
  localparam int PAD_W = PAGES * SW_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PARAMS - 1);
  localparam logic [3:0]       LAST_PAGE = 4'(PAGES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [3:0]       page, page_nxt;
  logic [3:0]       btn_q, evt;
  logic             nav_next, do_save, do_commit, do_restore;

  logic [BIT_WIDTH-1:0]            working [NUM_PARAMS];
  logic [NUM_PARAMS*BIT_WIDTH-1:0] params_q;
  logic                            upd_q;
  logic [SW_WIDTH-1:0]             led_q, led_cur;
  logic [6:0]                      hex3_q, hex2_q, hex1_q, hex0_q;
  logic [6:0]                      seg_page, seg_hi, seg_lo;
  logic [PAD_W-1:0]                pad_cur;
  logic [BIT_WIDTH-1:0]            field_wr;

  // A release (0 -> 1) on a debounced button is one event
  assign evt = bus.db_btn_n & ~btn_q;

`ifdef PARAM_BANK_PREV_EN
  logic nav_prev;
  // next and prev together cancel each other
  assign nav_next = evt[BTN_NEXT] & ~evt[BTN_PREV];
  assign nav_prev = evt[BTN_PREV] & ~evt[BTN_NEXT];
`else
  logic unused_prev;
  assign nav_next    = evt[BTN_NEXT];
  assign unused_prev = evt[BTN_PREV];
`endif

  // Position/state register and button history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      page  <= '0;
      btn_q <= 4'hF;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      page  <= page_nxt;
      btn_q <= bus.db_btn_n;
    end
  end

  // Navigation and edit decisions; abort beats everything, save lands before a move
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    page_nxt   = page;
    do_save    = 1'b0;
    do_commit  = 1'b0;
    do_restore = 1'b0;
    case (state)
      IDLE: begin
        if (nav_next) begin
          state_nxt = EDIT;
          idx_nxt   = '0;
          page_nxt  = '0;
        end
      end
      EDIT: begin
        if (evt[BTN_ABORT]) begin
          do_restore = 1'b1;
          state_nxt  = IDLE;
          idx_nxt    = '0;
          page_nxt   = '0;
        end else begin
          do_save = evt[BTN_SAVE];
          if (nav_next) begin
            if (page != LAST_PAGE) begin
              page_nxt = page + 4'd1;
            end else begin
              page_nxt = '0;
              if (idx == LAST_IDX) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                do_commit = 1'b1;
              end else begin
                idx_nxt = idx + 1'b1;
              end
            end
          end
`ifdef PARAM_BANK_PREV_EN
          else if (nav_prev) begin
            if (page != 4'd0) begin
              page_nxt = page - 4'd1;
            end else if (idx != '0) begin
              idx_nxt  = idx - 1'b1;
              page_nxt = LAST_PAGE;
            end
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current field with the switch page merged in; SW bits past the field top are dropped
  always_comb begin
    field_wr = working[idx];
    for (int b = 0; b < BIT_WIDTH; b++) begin
      if ((b / SW_WIDTH) == int'(page)) field_wr[b] = bus.SW[b % SW_WIDTH];
    end
  end

  assign pad_cur = PAD_W'(working[idx]);
  assign led_cur = pad_cur[int'(page)*SW_WIDTH +: SW_WIDTH];

  // Working copy edits, abort restore, and atomic publish on commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PARAMS; k++) working[k] <= '0;
      params_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= do_commit;
      if (do_restore) begin
        for (int k = 0; k < NUM_PARAMS; k++) working[k] <= params_q[k*BIT_WIDTH +: BIT_WIDTH];
      end else if (do_save) begin
        working[idx] <= field_wr;
      end
      if (do_commit) begin
        for (int k = 0; k < NUM_PARAMS; k++) begin
          params_q[k*BIT_WIDTH +: BIT_WIDTH] <= (do_save && idx == IDX_W'(k)) ? field_wr : working[k];
        end
      end
    end
  end

  hex7seg u_hex_page (.val(page), .seg(seg_page));
  hex7seg u_hex_lo   (.val(4'(idx)), .seg(seg_lo));

  generate
    if (IDX_W > 4) begin : g_idx_hi
      hex7seg u_hex_hi (.val(4'(idx >> 4)), .seg(seg_hi));
    end else begin : g_idx_dash
      assign seg_hi = SEG_DASH;
    end
  endgenerate

  // Registered LED and display outputs, one cycle behind state and data
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      led_q  <= '0;
      hex3_q <= SEG_I;
      hex2_q <= SEG_D;
      hex1_q <= SEG_L;
      hex0_q <= SEG_E;
    end else begin
      led_q  <= led_cur;
      hex3_q <= SEG_P;
      hex2_q <= seg_page;
      hex1_q <= seg_hi;
      hex0_q <= seg_lo;
    end
  end

  assign bus.params     = params_q;
  assign bus.params_upd = upd_q;
  assign bus.LEDR       = led_q;
  assign bus.HEX3       = hex3_q;
  assign bus.HEX2       = hex2_q;
  assign bus.HEX1       = hex1_q;
  assign bus.HEX0       = hex0_q;

endmodule

// File: tb/tb_param_bank.sv
// Directed bench for param_bank with 12 fields of 16 bits entered in 10-bit pages.
// Works in both builds; prev expectations follow PARAM_BANK_PREV_EN.
module tb_param_bank;

  localparam int NP = 12;
  localparam int BW = 16;
  localparam int SWW = 10;

  localparam logic [3:0] B_ABORT = 4'b1000;
  localparam logic [3:0] B_NEXT  = 4'b0100;
  localparam logic [3:0] B_SAVE  = 4'b0010;
  localparam logic [3:0] B_PREV  = 4'b0001;

  // Active-low glyphs, bit 0 = segment a
  localparam logic [6:0] G_0 = 7'h40, G_1 = 7'h79, G_3 = 7'h30, G_5 = 7'h12;
  localparam logic [6:0] G_7 = 7'h78, G_B = 7'h03, G_P = 7'h0C, G_DASH = 7'h3F;
  localparam logic [27:0] HEX_IDLE = {7'h79, 7'h21, 7'h47, 7'h06};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   upd_cnt = 0;
  int   upd_base;

  param_bank_if #(.NUM_PARAMS(NP), .BIT_WIDTH(BW), .SW_WIDTH(SWW)) bus ();

  param_bank #(.NUM_PARAMS(NP), .BIT_WIDTH(BW), .SW_WIDTH(SWW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.params_upd) upd_cnt++;

  function automatic logic [27:0] hex_now();
    return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  function automatic logic [BW-1:0] field(input int k);
    return bus.params[k*BW +: BW];
  endfunction

  // Press and release; returns once registered outputs reflect the event
  task automatic press(input logic [3:0] mask);
    @(negedge clk) bus.db_btn_n = ~mask;
    @(negedge clk) bus.db_btn_n = 4'hF;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic nexts(input int n);
    for (int i = 0; i < n; i++) press(B_NEXT);
  endtask

  task automatic test_reset();
    bus.SW = '0;
    bus.db_btn_n = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.params !== '0) begin errors++; $display("FAIL reset_params got=%h want=0", bus.params); end
    checks++; if (bus.LEDR !== 10'h0) begin errors++; $display("FAIL reset_ledr got=%h want=0", bus.LEDR); end
    checks++; if (hex_now() !== HEX_IDLE) begin errors++; $display("FAIL reset_hex got=%h want=%h", hex_now(), HEX_IDLE); end
    checks++; if (bus.params_upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b want=0", bus.params_upd); end
    // save/abort/prev released while idle do nothing
    bus.SW = 10'h3FF;
    press(B_SAVE);
    press(B_ABORT);
    press(B_PREV);
    press(B_SAVE | B_ABORT | B_PREV);
    checks++; if (hex_now() !== HEX_IDLE) begin errors++; $display("FAIL idle_ignore_hex got=%h want=%h", hex_now(), HEX_IDLE); end
    checks++; if (bus.params !== '0 || upd_cnt !== 0) begin errors++; $display("FAIL idle_ignore_params got=%h upd=%0d want=0 upd=0", bus.params, upd_cnt); end
  endtask

  task automatic test_paged_entry();
    press(B_NEXT);
    checks++; if (hex_now() !== {G_P, G_0, G_DASH, G_0}) begin errors++; $display("FAIL enter_hex got=%h want=%h", hex_now(), {G_P, G_0, G_DASH, G_0}); end
    checks++; if (bus.LEDR !== 10'h0) begin errors++; $display("FAIL enter_ledr got=%h want=0", bus.LEDR); end
    bus.SW = 10'h3A5;
    press(B_SAVE);
    checks++; if (bus.LEDR !== 10'h3A5) begin errors++; $display("FAIL page0_ledr got=%h want=3a5", bus.LEDR); end
    press(B_NEXT);
    bus.SW = 10'h02F;
    press(B_SAVE);
    checks++; if (bus.LEDR !== 10'h02F) begin errors++; $display("FAIL page1_ledr got=%h want=02f", bus.LEDR); end
    checks++; if (hex_now() !== {G_P, G_1, G_DASH, G_0}) begin errors++; $display("FAIL page1_hex got=%h want=%h", hex_now(), {G_P, G_1, G_DASH, G_0}); end
    // 22 nexts reach field 11 page 1 without publishing
    nexts(22);
    checks++; if (hex_now() !== {G_P, G_1, G_DASH, G_B}) begin errors++; $display("FAIL last_pos_hex got=%h want=%h", hex_now(), {G_P, G_1, G_DASH, G_B}); end
    checks++; if (bus.params !== '0 || upd_cnt !== 0) begin errors++; $display("FAIL params_stable got=%h upd=%0d want=0 upd=0", bus.params, upd_cnt); end
    press(B_NEXT);
    // page1 keeps the low 6 bits of 0x02F: 0x2F<<10 | 0x3A5 = 0xBFA5
    checks++; if (field(0) !== 16'hBFA5) begin errors++; $display("FAIL commit_field0 got=%h want=bfa5", field(0)); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL commit_upd got=%0d want=1", upd_cnt); end
    checks++; if (hex_now() !== HEX_IDLE) begin errors++; $display("FAIL commit_idle got=%h want=%h", hex_now(), HEX_IDLE); end
  endtask

  task automatic test_save_next();
    upd_base = upd_cnt;
    press(B_NEXT);
    nexts(6);
    bus.SW = 10'h155;
    press(B_SAVE | B_NEXT);
    checks++; if (hex_now() !== {G_P, G_1, G_DASH, G_3}) begin errors++; $display("FAIL savenext_pos got=%h want=%h", hex_now(), {G_P, G_1, G_DASH, G_3}); end
    checks++; if (bus.LEDR !== 10'h0) begin errors++; $display("FAIL savenext_ledr got=%h want=0", bus.LEDR); end
    nexts(17);
    checks++; if (field(3) !== 16'h0155) begin errors++; $display("FAIL savenext_field3 got=%h want=0155", field(3)); end
    checks++; if (field(0) !== 16'hBFA5 || upd_cnt !== upd_base + 1) begin errors++; $display("FAIL savenext_commit f0=%h upd=%0d want=bfa5 upd=%0d", field(0), upd_cnt, upd_base + 1); end
  endtask

  task automatic test_abort();
    upd_base = upd_cnt;
    press(B_NEXT);
    checks++; if (bus.LEDR !== 10'h3A5) begin errors++; $display("FAIL reenter_ledr got=%h want=3a5", bus.LEDR); end
    nexts(6);
    checks++; if (bus.LEDR !== 10'h155) begin errors++; $display("FAIL field3_ledr got=%h want=155", bus.LEDR); end
    nexts(4);
    bus.SW = 10'h0FF;
    press(B_SAVE);
    checks++; if (bus.LEDR !== 10'h0FF || hex_now() !== {G_P, G_0, G_DASH, G_5}) begin errors++; $display("FAIL field5_edit ledr=%h hex=%h want 0ff %h", bus.LEDR, hex_now(), {G_P, G_0, G_DASH, G_5}); end
    press(B_NEXT);
    bus.SW = 10'h000;
    press(B_SAVE);
    press(B_ABORT);
    checks++; if (hex_now() !== HEX_IDLE) begin errors++; $display("FAIL abort_idle got=%h want=%h", hex_now(), HEX_IDLE); end
    checks++; if (field(5) !== 16'h0 || field(3) !== 16'h0155 || field(0) !== 16'hBFA5) begin errors++; $display("FAIL abort_params f5=%h f3=%h f0=%h want 0000 0155 bfa5", field(5), field(3), field(0)); end
    checks++; if (upd_cnt !== upd_base) begin errors++; $display("FAIL abort_upd got=%0d want=%0d", upd_cnt, upd_base); end
    press(B_NEXT);
    nexts(10);
    checks++; if (bus.LEDR !== 10'h0) begin errors++; $display("FAIL abort_restored got=%h want=0", bus.LEDR); end
    press(B_ABORT);
  endtask

  task automatic test_prev();
    press(B_NEXT);
    press(B_PREV);
    checks++; if (hex_now() !== {G_P, G_0, G_DASH, G_0}) begin errors++; $display("FAIL prev_at_origin got=%h want=%h", hex_now(), {G_P, G_0, G_DASH, G_0}); end
    nexts(2);
    press(B_PREV);
`ifdef PARAM_BANK_PREV_EN
    checks++; if (hex_now() !== {G_P, G_1, G_DASH, G_0}) begin errors++; $display("FAIL prev_wrap_page got=%h want=%h", hex_now(), {G_P, G_1, G_DASH, G_0}); end
    press(B_NEXT | B_PREV);
    checks++; if (hex_now() !== {G_P, G_1, G_DASH, G_0}) begin errors++; $display("FAIL next_prev_cancel got=%h want=%h", hex_now(), {G_P, G_1, G_DASH, G_0}); end
`else
    checks++; if (hex_now() !== {G_P, G_0, G_DASH, G_1}) begin errors++; $display("FAIL prev_ignored got=%h want=%h", hex_now(), {G_P, G_0, G_DASH, G_1}); end
    press(B_NEXT | B_PREV);
    checks++; if (hex_now() !== {G_P, G_1, G_DASH, G_1}) begin errors++; $display("FAIL next_with_prev got=%h want=%h", hex_now(), {G_P, G_1, G_DASH, G_1}); end
`endif
    press(B_ABORT);
  endtask

  task automatic test_reset_mid_edit();
    upd_base = upd_cnt;
    press(B_NEXT);
    nexts(14);
    checks++; if (hex_now() !== {G_P, G_0, G_DASH, G_7}) begin errors++; $display("FAIL idx7_pos got=%h want=%h", hex_now(), {G_P, G_0, G_DASH, G_7}); end
    bus.SW = 10'h3FF;
    press(B_SAVE);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.params !== '0) begin errors++; $display("FAIL midrst_params got=%h want=0", bus.params); end
    checks++; if (hex_now() !== HEX_IDLE || bus.LEDR !== 10'h0) begin errors++; $display("FAIL midrst_idle hex=%h ledr=%h want %h 0", hex_now(), bus.LEDR, HEX_IDLE); end
    checks++; if (upd_cnt !== upd_base) begin errors++; $display("FAIL midrst_upd got=%0d want=%0d", upd_cnt, upd_base); end
    press(B_NEXT);
    nexts(14);
    checks++; if (bus.LEDR !== 10'h0) begin errors++; $display("FAIL midrst_working got=%h want=0", bus.LEDR); end
  endtask

  initial begin
    test_reset();
    test_paged_entry();
    test_save_next();
    test_abort();
    test_prev();
    test_reset_mid_edit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
